// File: rtl/arctic_scanout.sv
// Snapshot readout stage: captures every node nibble into a shadow buffer and streams
// the frame two nodes per byte. Define ARCTIC_SCAN_HEADER_EN to prefix each frame with a count byte.
module arctic_scanout #(
    parameter int unsigned NODES = 16,
    parameter int unsigned N     = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NODES*(N+1)-1:0] nodes_in,
    input  logic                   snap,
    output logic                   busy,
    output logic [7:0]             data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   last,
    output logic                   overrun
);

    localparam int unsigned Bytes = NODES / 2;
    localparam int unsigned IdxW  = (Bytes > 1) ? $clog2(Bytes) : 1;
    localparam int unsigned W     = NODES * (N + 1);

    typedef enum logic [1:0] {StIdle, StHdr, StSend} state_e;

`ifdef ARCTIC_SCAN_HEADER_EN
    localparam state_e StFirst = StHdr;
`else
    localparam state_e StFirst = StSend;
`endif

    state_e            state_q, state_d;
    logic [W-1:0]      shadow_q, shadow_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
`ifdef ARCTIC_SCAN_HEADER_EN
    logic [3:0]        frame_cnt_q, frame_cnt_d;
`endif

    logic xfer, last_xfer, capture;

    assign xfer      = valid_q & out_ready;
    assign last_xfer = (state_q == StSend) & last_q & xfer;
    // A request is honoured when idle or exactly on the last-byte transfer.
    assign capture   = snap & ((state_q == StIdle) | last_xfer);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shadow_q    <= '0;
            idx_q       <= '0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef ARCTIC_SCAN_HEADER_EN
            frame_cnt_q <= 4'h0;
`endif
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
`ifdef ARCTIC_SCAN_HEADER_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        overrun_d = overrun_q | (snap & busy_q & ~last_xfer);
        unique case (state_q)
            StIdle: begin
                if (capture) state_d = StFirst;
            end
            StHdr: begin
                if (xfer) state_d = StSend;
            end
            StSend: begin
                if (xfer) begin
                    if (last_q) state_d = capture ? StFirst : StIdle;
                    else        idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (capture) begin
            shadow_d = nodes_in;
            idx_d    = '0;
        end
`ifdef ARCTIC_SCAN_HEADER_EN
        frame_cnt_d = frame_cnt_q + {3'b000, capture};
`endif
    end

    // Outputs are registered, so they are derived from the next state.
    always_comb begin
        data_d  = 8'h00;
        valid_d = (state_d != StIdle);
        busy_d  = (state_d != StIdle);
        last_d  = 1'b0;
        unique case (state_d)
            StIdle: data_d = 8'h00;
            StHdr: begin
`ifdef ARCTIC_SCAN_HEADER_EN
                data_d = {4'hA, frame_cnt_q};
`endif
            end
            StSend: begin
                data_d = shadow_d[8*int'(idx_d) +: 8];
                last_d = (idx_d == IdxW'(Bytes - 1));
            end
            default: data_d = 8'h00;
        endcase
    end

    assign busy      = busy_q;
    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign last      = last_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_arctic_scanout.sv
// Bench for arctic_scanout: directed steps plus random traffic against a byte-queue frame model.
module tb_arctic_scanout;

    localparam int unsigned NODES = 16;
    localparam int unsigned W     = NODES * 4;
    localparam int unsigned Bytes = NODES / 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] nodes_in = '0;
    logic         snap = 1'b0;
    logic         out_ready = 1'b0;
    logic         busy, out_valid, last, overrun;
    logic [7:0]   data_out;

    int checks = 0;
    int errors = 0;

    // Model: bytes still owed for the current frame; empty means idle.
    logic [7:0] q[$];
    logic       m_ovr = 1'b0;
    logic [3:0] m_cnt = 4'h0;

    always #5 clk = ~clk;

    arctic_scanout #(.NODES(NODES), .N(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nodes_in  (nodes_in),
        .snap      (snap),
        .busy      (busy),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last      (last),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            q.delete();
            m_ovr = 1'b0;
            m_cnt = 4'h0;
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (snap) begin
                if (q.size() == 0) begin
`ifdef ARCTIC_SCAN_HEADER_EN
                    q.push_back({4'hA, m_cnt});
                    m_cnt = m_cnt + 4'h1;
`endif
                    for (int i = 0; i < Bytes; i++) q.push_back(nodes_in[8*i +: 8]);
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        chk("data_out", 32'(data_out), (q.size() > 0) ? 32'(q[0]) : 32'h0);
        chk("last", 32'(last), 32'(q.size() == 1));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        snap = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'h0);
        cyc();
    endtask

    task automatic ramp_nodes();
        for (int k = 0; k < NODES; k++) nodes_in[4*k +: 4] = 4'(k % 16);
    endtask

    task automatic rand_nodes();
        for (int k = 0; k < NODES; k++) nodes_in[4*k +: 4] = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int n;
        // Reset held for two cycles.
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("reset_data", 32'(data_out), 32'h0);
        rst_n = 1'b1;
        cyc();

        // Basic ramp frame.
        ramp_nodes();
        snap = 1'b1;
        out_ready = 1'b1;
        cyc();
        snap = 1'b0;
        drain();

        // Backpressure on byte 2 while nodes_in changes.
        ramp_nodes();
        snap = 1'b1;
        cyc();
        snap = 1'b0;
        cyc();
        cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_nodes();
            cyc();
        end
`ifdef ARCTIC_SCAN_HEADER_EN
        chk("hold_byte", 32'(data_out), 32'h32);
`else
        chk("hold_byte", 32'(data_out), 32'h54);
`endif
        drain();

        // Mid-frame snap is dropped; snap on last-byte transfer chains frames.
        rand_nodes();
        snap = 1'b1;
        cyc();
        snap = 1'b0;
        cyc();
        snap = 1'b1;
        cyc();
        snap = 1'b0;
        chk("overrun_set", 32'(overrun), 32'h1);
        n = 0;
        while (q.size() != 1 && n < 50) begin
            cyc();
            n++;
        end
        chk("reach_last", 32'(last), 32'h1);
        rand_nodes();
        snap = 1'b1;
        cyc();
        snap = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'h1);
        drain();
        chk("overrun_sticky", 32'(overrun), 32'h1);

        // Reset mid-frame.
        ramp_nodes();
        snap = 1'b1;
        cyc();
        snap = 1'b0;
        cyc();
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        chk("rst_mid_ovr", 32'(overrun), 32'h0);
        snap = 1'b1;
        cyc();
        snap = 1'b0;
        drain();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            snap = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) rand_nodes();
            cyc();
        end
        drain();

        // Seventeen frames after a reset; header counts wrap.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int f = 0; f < 17; f++) begin
            rand_nodes();
            snap = 1'b1;
            out_ready = 1'b1;
            cyc();
            snap = 1'b0;
`ifdef ARCTIC_SCAN_HEADER_EN
            chk("header", 32'(data_out), 32'({4'hA, 4'(f % 16)}));
            chk("header_last", 32'(last), 32'h0);
`endif
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arctic_scanout.md
# arctic_scanout

Downstream readout stage for the Arctic Circle node array. On a snapshot request it captures the registered `out` nibble of every node into a shadow buffer, then streams the frame out two nodes per byte over a valid/ready handshake. This decouples the free-running node grid from the narrow, slow output pins.

## Interface

Parameters:
- `NODES`, 16: number of nodes captured per frame; must be even, range 2..256.
- `N`, 3: node state width minus one; node nibble is `N+1` = 4 bits. Only `N`=3 is supported.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `nodes_in`  in  `NODES*(N+1)`  flattened node states; node k occupies bits `[4k+3:4k]`.
- `snap`  in  1  capture request, sampled every cycle.
- `busy`  out  1  a frame is held or being streamed.
- `data_out`  out  8  output byte.
- `out_valid`  out  1  `data_out` is valid.
- `out_ready`  in  1  consumer accepts the byte this cycle.
- `last`  out  1  current byte is the final byte of the frame.
- `overrun`  out  1  sticky: a snapshot request was dropped.

## Operation

- States: IDLE, HDR (only with header enabled), SEND.
- IDLE: `busy`=0, `out_valid`=0. On `snap`=1: latch `nodes_in` into the shadow buffer, clear the byte index to 0, go to HDR if enabled, else SEND.
- SEND: `out_valid`=1. `data_out` = {node 2i+1, node 2i}, where i is the byte index; the odd node is in the high nibble. `last`=1 when i = `NODES/2`-1.
- Transfer occurs when `out_valid && out_ready`. On transfer, i increments. On transfer of the last byte: if `snap`=1 in the same cycle, capture a new frame and restart (HDR or SEND with i=0); otherwise go to IDLE.
- While `out_valid && !out_ready`, `data_out` and `last` are held stable.
- `snap`=1 in any cycle where `busy`=1, except the last-byte transfer cycle, is ignored and sets `overrun`=1. `overrun` clears only on reset.
- Byte index width: `$clog2(NODES/2)`, minimum 1 bit. The index never exceeds `NODES/2`-1.
- The shadow buffer changes only on capture. Changes on `nodes_in` during streaming do not affect output.

## Timing

- Reset values: `busy`=0, `out_valid`=0, `last`=0, `data_out`=8'h00, `overrun`=0, frame counter=0, state=IDLE, shadow buffer all zero.
- All outputs are registered.
- Capture latency: `snap` sampled at edge t; `out_valid`=1 and `busy`=1 from edge t (visible in cycle t+1).
- With `out_ready` held at 1, a frame takes `NODES/2` cycles, plus 1 with the header. Back-to-back frames have no idle cycle.
- `busy` falls on the edge that transfers the last byte, unless a new capture occurs on that edge.
- Reset asserted mid-frame aborts the frame immediately. All outputs return to their reset values at that edge.

## Configuration

- `ARCTIC_SCAN_HEADER_EN` defined:
  - Each frame begins with one header byte {4'hA, frame_cnt[3:0]} in state HDR; `last`=0 for the header.
  - `frame_cnt` increments on every capture and wraps from 15 to 0. The first frame after reset carries count 0.
  - HDR moves to SEND on transfer.
- Not defined: no HDR state and no counter. Frames contain only `NODES/2` data bytes.

## Test plan

- Reset with `NODES`=16: hold `rst_n`=0 for 2 cycles -> all outputs 0, `busy`=0.
- Basic frame: `nodes_in` = node k value k mod 16, `snap` pulse, `out_ready`=1 -> bytes 8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE; `last` only on 8'hFE; `busy` low the next cycle.
- Backpressure: `out_ready`=0 for 5 cycles at byte 2 -> `data_out` holds 8'h54 stable with `out_valid`=1. Change `nodes_in` meanwhile -> remaining bytes unchanged.
- Overrun and back-to-back: `snap` mid-frame -> ignored, `overrun`=1 and stays 1. `snap` on the last-byte transfer cycle -> new frame's first byte appears the next cycle with no gap.
- Reset mid-frame at byte 3 -> next cycle `out_valid`=0, `overrun`=0. A fresh `snap` restarts from byte 0.
- With `ARCTIC_SCAN_HEADER_EN`: 17 consecutive frames -> headers 8'hA0 .. 8'hAF, then 8'hA0. Each frame is 9 bytes, and `last` is never set on a header.
